// File: rtl/qdiv_pkg.sv
// Shared types and helpers for the sequential sign-magnitude Q-format divider.
// Contents: FSM state encoding, per-bit magnitude saturation helper.
package qdiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } qdiv_state_t;

  // Saturate one magnitude bit: forced to 1 when the result saturates.
  // Applied bit-wise so the helper stays independent of the word width.
  function automatic logic sat_mag_bit(input logic sat, input logic mag_bit);
    return sat | mag_bit;
  endfunction

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift the partial remainder left, bring in the
// next dividend bit, trial-subtract the divisor magnitude.
// Ports:
//   rem_i   - current partial remainder (always < dvs_i)
//   bit_i   - next dividend bit, MSB first
//   dvs_i   - divisor magnitude
//   rem_o   - new partial remainder
//   qbit_o  - quotient bit produced by this step
module qdiv_step #(
  parameter int unsigned MW = 15
) (
  input  logic [MW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [MW-1:0] dvs_i,
  output logic [MW-1:0] rem_o,
  output logic          qbit_o
);

  logic [MW:0] shifted;
  logic [MW:0] diff;

  // Remainder < divisor before the shift, so the kept value always fits MW bits.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {1'b0, dvs_i};
    qbit_o  = (shifted >= {1'b0, dvs_i});
    rem_o   = qbit_o ? diff[MW-1:0] : shifted[MW-1:0];
  end

endmodule

// File: rtl/qdiv_seq.sv
// Sequential sign-magnitude Q-format divider, one quotient bit per clock.
// Optional build macro: QDIV_ROUND_EN (round half up instead of truncation).
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   i_start      - request a divide (sampled only in IDLE)
//   i_dividend   - sign-magnitude dividend, captured on accepted start
//   i_divisor    - sign-magnitude divisor, captured on accepted start
//   o_busy       - high while iterating
//   o_done       - one-cycle pulse when o_result is valid
//   o_result     - sign-magnitude quotient, held until next accepted start
//   o_ovr        - quotient magnitude saturated
//   o_dbz        - divide by zero
module qdiv_seq
  import qdiv_pkg::*;
#(
  parameter int unsigned Q = 8,
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_result,
  output logic         o_ovr,
  output logic         o_dbz
);

  localparam int unsigned MW    = N - 1;
  localparam int unsigned ITER  = N - 1 + Q;
  localparam int unsigned CNT_W = $clog2(ITER + 1);

  qdiv_state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ITER-1:0]  dvd_q, dvd_d;
  logic [ITER-1:0]  quo_q, quo_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic [MW-1:0]    dvs_q, dvs_d;
  logic             sign_q, sign_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N-1:0]     result_q, result_d;
  logic             ovr_q, ovr_d;
  logic             dbz_q, dbz_d;

  logic [MW-1:0]    rem_nx;
  logic             qbit_nx;
  logic [ITER-1:0]  quo_fin;
  logic [MW-1:0]    mag_pre;
  logic [MW-1:0]    mag_sat;
  logic             ovr_fin;
  logic             start_ok;
  logic             dvs_zero;

  qdiv_step #(.MW(MW)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[ITER-1]),
    .dvs_i  (dvs_q),
    .rem_o  (rem_nx),
    .qbit_o (qbit_nx)
  );

  assign start_ok = (state_q == IDLE) && i_start;
  assign dvs_zero = (i_divisor[N-2:0] == '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (i_start) state_d = dvs_zero ? DONE : RUN;
      RUN:  if (cnt_q == CNT_W'(ITER - 1)) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final quotient/result as it stands after the last iteration step.
  always_comb begin
    quo_fin = {quo_q[ITER-2:0], qbit_nx};
`ifdef QDIV_ROUND_EN
    begin
      logic          rnd;
      logic [MW:0]   mag_sum;
      rnd     = ({rem_nx, 1'b0} >= {1'b0, dvs_q});
      mag_sum = {1'b0, quo_fin[MW-1:0]} + (MW+1)'(rnd);
      ovr_fin = (|quo_fin[ITER-1:MW]) | mag_sum[MW];
      mag_pre = mag_sum[MW-1:0];
    end
`else
    ovr_fin = |quo_fin[ITER-1:MW];
    mag_pre = quo_fin[MW-1:0];
`endif
    for (int i = 0; i < int'(MW); i++) begin
      mag_sat[i] = sat_mag_bit(ovr_fin, mag_pre[i]);
    end
  end

  // Next values of datapath and output registers.
  always_comb begin
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    sign_d   = sign_q;
    result_d = result_q;
    ovr_d    = ovr_q;
    dbz_d    = dbz_q;
    done_d   = 1'b0;
    busy_d   = (state_d == RUN);

    if (start_ok) begin
      // Dividend magnitude extended with Q zero LSBs, consumed MSB first.
      dvd_d  = ITER'(i_dividend[N-2:0]) << Q;
      dvs_d  = i_divisor[N-2:0];
      sign_d = i_dividend[N-1] ^ i_divisor[N-1];
      quo_d  = '0;
      rem_d  = '0;
      cnt_d  = '0;
      ovr_d  = 1'b0;
      dbz_d  = 1'b0;
      if (dvs_zero) begin
        done_d   = 1'b1;
        dbz_d    = 1'b1;
        result_d = {i_dividend[N-1] ^ i_divisor[N-1], {MW{1'b1}}};
      end
    end else if (state_q == RUN) begin
      dvd_d = dvd_q << 1;
      rem_d = rem_nx;
      quo_d = quo_fin;
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d == DONE) begin
        done_d   = 1'b1;
        ovr_d    = ovr_fin;
        result_d = {sign_q, mag_sat};
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      dvd_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      sign_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovr_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      dvd_q    <= dvd_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      sign_q   <= sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovr_q    <= ovr_d;
      dbz_q    <= dbz_d;
    end
  end

  assign o_busy   = busy_q;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_ovr    = ovr_q;
  assign o_dbz    = dbz_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// Directed self-checking bench for qdiv_seq (Q=8, N=16).
// Honours QDIV_ROUND_EN for the 2/3 rounding vector.
module tb_qdiv_seq;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic [15:0] i_dividend;
  logic [15:0] i_divisor;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_result;
  logic        o_ovr;
  logic        o_dbz;

  int n_assert = 0;
  int n_fail   = 0;

  qdiv_seq #(.Q(8), .N(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result),
    .o_ovr      (o_ovr),
    .o_dbz      (o_dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Start a divide, scramble operands after the start edge, wait for done
  // (bounded), then check latency, busy cycles, result, flags and pulse width.
  task automatic do_div(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] er, input logic eo, input logic ed,
                        input int elat, input int ebusy);
    int edges;
    int busy_cnt;
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start    = 1'b0;
    i_dividend = 16'($urandom);
    i_divisor  = 16'($urandom);
    edges    = 0;
    busy_cnt = 0;
    while (!o_done && edges < 40) begin
      if (o_busy) busy_cnt++;
      @(posedge clk); #1;
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'(elat));
    check({tag, " busy"},    32'(busy_cnt), 32'(ebusy));
    check({tag, " result"},  32'(o_result), 32'(er));
    check({tag, " ovr"},     32'(o_ovr), 32'(eo));
    check({tag, " dbz"},     32'(o_dbz), 32'(ed));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 32'(o_done), 32'd0);
    check({tag, " held"},       32'(o_result), 32'(er));
  endtask

  initial begin
    int edges;
    int done_cnt;
    int busy_cnt;

    rst_n      = 1'b0;
    i_start    = 1'b0;
    i_dividend = '0;
    i_divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",   32'(o_busy), 32'd0);
    check("rst done",   32'(o_done), 32'd0);
    check("rst result", 32'(o_result), 32'd0);
    check("rst ovr",    32'(o_ovr), 32'd0);
    check("rst dbz",    32'(o_dbz), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic and sign combinations.
    do_div("3/2",   16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 23, 23);
    do_div("-3/2",  16'h8300, 16'h0200, 16'h8180, 1'b0, 1'b0, 23, 23);
    do_div("3/-2",  16'h0300, 16'h8200, 16'h8180, 1'b0, 1'b0, 23, 23);
    do_div("-3/-2", 16'h8300, 16'h8200, 16'h0180, 1'b0, 1'b0, 23, 23);

    // 2/3: remainder 512, 2*512 >= 768 so rounding bumps 0xAA to 0xAB.
`ifdef QDIV_ROUND_EN
    do_div("2/3",   16'h0200, 16'h0300, 16'h00AB, 1'b0, 1'b0, 23, 23);
`else
    do_div("2/3",   16'h0200, 16'h0300, 16'h00AA, 1'b0, 1'b0, 23, 23);
`endif

    // Overflow then recovery with flag cleared.
    do_div("127/0.5", 16'h7F00, 16'h0080, 16'h7FFF, 1'b1, 1'b0, 23, 23);
    do_div("1/1",     16'h0100, 16'h0100, 16'h0100, 1'b0, 1'b0, 23, 23);

    // Divide by zero (including -0 and 0/0).
    do_div("1/-0",  16'h0100, 16'h8000, 16'hFFFF, 1'b0, 1'b1, 0, 0);
    do_div("0/0",   16'h0000, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 0, 0);

    // Zero dividend.
    do_div("0/3",   16'h0000, 16'h0300, 16'h0000, 1'b0, 1'b0, 23, 23);
    do_div("-0/3",  16'h8000, 16'h0300, 16'h8000, 1'b0, 1'b0, 23, 23);

    // Second start mid-RUN must be ignored.
    i_dividend = 16'h0300;
    i_divisor  = 16'h0200;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start  = 1'b0;
    edges    = 0;
    done_cnt = 0;
    repeat (5) begin
      @(posedge clk); #1;
      edges++;
    end
    i_dividend = 16'h0100;
    i_divisor  = 16'h0100;
    i_start    = 1'b1;
    @(posedge clk); #1;
    edges++;
    i_start = 1'b0;
    while (!o_done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    check("restart latency", 32'(edges), 32'd23);
    check("restart result",  32'(o_result), 32'h0180);
    repeat (30) begin
      @(posedge clk); #1;
      if (o_done) done_cnt++;
    end
    check("restart extra done", 32'(done_cnt), 32'd0);

    // Asynchronous reset mid-RUN.
    i_dividend = 16'h0200;
    i_divisor  = 16'h0300;
    i_start    = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("pre-rst busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst busy",   32'(o_busy), 32'd0);
    check("midrst done",   32'(o_done), 32'd0);
    check("midrst result", 32'(o_result), 32'd0);
    check("midrst ovr",    32'(o_ovr), 32'd0);
    check("midrst dbz",    32'(o_dbz), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (o_done) done_cnt++;
      if (o_busy) busy_cnt++;
    end
    check("postrst done", 32'(done_cnt), 32'd0);
    check("postrst busy", 32'(busy_cnt), 32'd0);

    // Back in IDLE: a fresh divide works normally.
    do_div("post 3/2", 16'h0300, 16'h0200, 16'h0180, 1'b0, 1'b0, 23, 23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
